// File: rtl/cpu_sequencer.sv
// Fetch/execute controller for the 4-bit CPU core: owns the architectural registers,
// fetches from a synchronous ROM and commits the external ALU result once per step.
package cpu_pkg;
  typedef enum logic [3:0] {
    ADD_A_IMM = 4'h0, MOV_A_B   = 4'h1, IN_A      = 4'h2, MOV_A_IMM = 4'h3,
    MOV_B_A   = 4'h4, ADD_B_IMM = 4'h5, IN_B      = 4'h6, MOV_B_IMM = 4'h7,
    OUT_B     = 4'h9, OUT_IMM   = 4'hB, JNC_IMM   = 4'hE, JMP_IMM   = 4'hF
  } opecode_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cf;
    logic [3:0] ip;
    logic [3:0] out;
  } regs_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_EXEC = 2'd2} state_t;
endpackage

module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned TICK_DIV = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  output opecode_t   alu_opecode,
  output logic [3:0] alu_imm,
  output regs_t      alu_current,
  input  regs_t      alu_next,
  output regs_t      regs,
  output logic       busy,
  output logic       retired,
  output logic       halted,
  output state_t     dbg_state
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  state_t          state_q;
  regs_t           regs_q;
  logic [7:0]      instr_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            step_q;
  logic            halted_q;
  logic            trigger;

  // Leaving run mode drops the counter to 0, discarding any partial count.
  always_comb begin
    cnt_d = '0;
    if (run) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  assign trigger = run ? (cnt_q == CNT_LAST) : (step && !step_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      regs_q   <= '0;
      instr_q  <= '0;
      cnt_q    <= '0;
      step_q   <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step;
      case (state_q)
        S_IDLE: begin
          if (trigger && !halted_q) state_q <= S_FETCH;
        end
        S_FETCH: begin
          instr_q <= rom_data;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          regs_q <= alu_next;
          // A jump to its own address can never make progress again.
          if (alu_opecode == JMP_IMM && alu_imm == regs_q.ip) halted_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rom_addr    = regs_q.ip;
  assign alu_opecode = opecode_t'(instr_q[7:4]);
  assign alu_imm     = instr_q[3:0];
  assign alu_current = regs_q;
  assign regs        = regs_q;
  assign busy        = (state_q != S_IDLE);
  assign retired     = (state_q == S_EXEC);
  assign halted      = halted_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: ROM and ALU models, table-driven single steps,
// plus hand-written sequences for run mode, reset abort and step-at-reset.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       step;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  opecode_t   alu_opecode;
  logic [3:0] alu_imm;
  regs_t      alu_current;
  regs_t      alu_next;
  regs_t      regs;
  logic       busy;
  logic       retired;
  logic       halted;
  state_t     dbg_state;

  logic [7:0] rom [16];
  int n_tests = 0;
  int n_fail  = 0;

  cpu_sequencer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .alu_opecode(alu_opecode), .alu_imm(alu_imm),
    .alu_current(alu_current), .alu_next(alu_next),
    .regs(regs), .busy(busy), .retired(retired), .halted(halted),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  function automatic regs_t alu_model(input logic [3:0] op, input logic [3:0] imm, input regs_t r);
    regs_t n;
    logic [4:0] s;
    n = r;
    n.cf = 1'b0;
    n.ip = r.ip + 4'd1;
    case (op)
      4'h0: begin
        s = {1'b0, r.a} + {1'b0, imm};
        n.a = s[3:0];
        n.cf = s[4];
      end
      4'h3: n.a = imm;
      4'hE: if (!r.cf) n.ip = imm;
      4'hF: n.ip = imm;
      default: ;
    endcase
    return n;
  endfunction

  always_comb alu_next = alu_model(alu_opecode, alu_imm, alu_current);

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full step request: rising edge, then enough cycles for fetch, exec and commit.
  task automatic do_step(output logic saw_ret);
    saw_ret = 1'b0;
    step = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (retired) saw_ret = 1'b1;
      step = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0] a;
    logic       cf;
    logic [3:0] ip;
    logic       halted;
    logic       ret;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic saw;
    int   nret;
    regs_t snap;

    tbl[0] = '{a: 4'h1, cf: 1'b0, ip: 4'h1, halted: 1'b0, ret: 1'b1}; // MOV_A_IMM 1
    tbl[1] = '{a: 4'h0, cf: 1'b1, ip: 4'h2, halted: 1'b0, ret: 1'b1}; // ADD_A_IMM F carries
    tbl[2] = '{a: 4'h0, cf: 1'b0, ip: 4'h3, halted: 1'b0, ret: 1'b1}; // JNC not taken
    tbl[3] = '{a: 4'h0, cf: 1'b0, ip: 4'h3, halted: 1'b1, ret: 1'b1}; // JMP 3 self-jump
    tbl[4] = '{a: 4'h0, cf: 1'b0, ip: 4'h3, halted: 1'b1, ret: 1'b0}; // halted: ignored

    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h35;
    rom[1] = 8'h0F;
    rom[2] = 8'hE9;
    rom[3] = 8'hF3;

    // Reset with step already high: not a request after release.
    rst = 1'b1; run = 1'b0; step = 1'b1;
    #12;
    check("rst_regs", 32'(regs), 32'h0);
    check("rst_retired", 32'(retired), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    rst = 1'b0;
    nret = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy) nret++;
    end
    check("held_step_no_exec", 32'(nret), 32'h0);

    // Single step with a dropped edge during EXEC.
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    check("t1_fetch_state", 32'(dbg_state), 32'(S_FETCH));
    check("t1_fetch_noret", 32'(retired), 32'h0);
    step = 1'b0;
    tick();
    check("t1_exec_retired", 32'(retired), 32'h1);
    check("t1_exec_opcode", 32'(alu_opecode), 32'(MOV_A_IMM));
    check("t1_exec_imm", 32'(alu_imm), 32'h5);
    step = 1'b1;
    tick();
    check("t1_a", 32'(regs.a), 32'h5);
    check("t1_ip", 32'(regs.ip), 32'h1);
    check("t1_idle_noret", 32'(retired), 32'h0);
    tick();
    check("t1_dropped_edge", 32'(busy), 32'h0);
    step = 1'b0;
    tick();

    // Table-driven program: MOV 1, ADD F, JNC 9, JMP 3, then halted.
    pulse_reset();
    rom[0] = 8'h31;
    tick();
    for (int i = 0; i < 5; i++) begin
      do_step(saw);
      check($sformatf("tbl%0d_retired", i), 32'(saw), 32'(tbl[i].ret));
      check($sformatf("tbl%0d_a", i), 32'(regs.a), 32'(tbl[i].a));
      check($sformatf("tbl%0d_cf", i), 32'(regs.cf), 32'(tbl[i].cf));
      check($sformatf("tbl%0d_ip", i), 32'(regs.ip), 32'(tbl[i].ip));
      check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].halted));
    end

    // Reset while in EXEC aborts the commit; also clears halted.
    pulse_reset();
    check("halt_cleared", 32'(halted), 32'h0);
    tick();
    do_step(saw);
    check("t5_pre_a", 32'(regs.a), 32'h1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    check("t5_in_exec", 32'(retired), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t5_regs", 32'(regs), 32'h0);
    check("t5_retired", 32'(retired), 32'h0);
    check("t5_halted", 32'(halted), 32'h0);
    #1 rst = 1'b0;
    tick();
    check("t5_no_commit", 32'(regs), 32'h0);

    // Run mode: retire every 4 cycles, pause discards the count.
    run = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("run1_k%0d", k), 32'(retired), 32'((k == 5) || (k == 9)));
    end
    run = 1'b0;
    nret = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (retired) nret++;
    end
    check("pause_no_retire", 32'(nret), 32'h0);
    check("pause_a", 32'(regs.a), 32'h0);
    check("pause_cf", 32'(regs.cf), 32'h1);
    check("pause_ip", 32'(regs.ip), 32'h2);
    run = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("run2_k%0d", k), 32'(retired), 32'((k == 5) || (k == 9)));
      if (k == 8) check("run2_jnc_ip", 32'(regs.ip), 32'h3);
    end
    tick();
    check("run_halted", 32'(halted), 32'h1);
    snap = regs;
    nret = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (retired) nret++;
    end
    check("halt_no_retire", 32'(nret), 32'h0);
    check("halt_regs_const", 32'(regs), 32'(snap));
    check("halt_ip", 32'(regs.ip), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
